// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between the core (port 0)
// and the UART loader/debug port (port 1). Round-robin arbitration with a
// bounded port-1 lock for burst loads; grants and RAM controls are combinational,
// read-valid flags are registered one cycle after a granted read.
module ram_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  logic             last_winner_q, last_winner_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             m0_rvalid_q, m0_rvalid_d;
  logic             m1_rvalid_q, m1_rvalid_d;
  logic             gnt0, gnt1;
  logic             lock_hold;

  // Grant decision: single requester wins; contest goes to lock holder, else round-robin
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    lock_hold = m1_lock & last_winner_q & m1_req & (lock_cnt_q < CNT_W'(LOCK_MAX));
    if (!rst) begin
      if (m0_req && m1_req) begin
        if (lock_hold || !last_winner_q) gnt1 = 1'b1;
        else                             gnt0 = 1'b1;
      end else if (m0_req) begin
        gnt0 = 1'b1;
      end else if (m1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Next-state: winner history, lock length counter, read-valid flags
  always_comb begin
    last_winner_d = last_winner_q;
    lock_cnt_d    = lock_cnt_q;
    if (gnt0) last_winner_d = 1'b0;
    if (gnt1) last_winner_d = 1'b1;
    // Any port-1 grant while the core waits under lock counts toward the bound,
    // so the core gets exactly one slot per LOCK_MAX port-1 grants.
    if (gnt0 || !m1_lock) begin
      lock_cnt_d = '0;
    end else if (gnt1 && m0_req && (lock_cnt_q < CNT_W'(LOCK_MAX))) begin
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end
    m0_rvalid_d = gnt0 & ~m0_we;
    m1_rvalid_d = gnt1 & ~m1_we;
  end

  // State registers, asynchronously cleared so a pending rvalid is discarded on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_winner_q <= 1'b1;
      lock_cnt_q    <= '0;
      m0_rvalid_q   <= 1'b0;
      m1_rvalid_q   <= 1'b0;
    end else begin
      last_winner_q <= last_winner_d;
      lock_cnt_q    <= lock_cnt_d;
      m0_rvalid_q   <= m0_rvalid_d;
      m1_rvalid_q   <= m1_rvalid_d;
    end
  end

  // RAM control mux: granted port drives the RAM, idle cycles park on port 0
  always_comb begin
    ram_addr  = m0_addr;
    ram_wdata = m0_wdata;
    ram_wren  = 1'b0;
    if (gnt1) begin
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
      ram_wren  = m1_we;
    end else if (gnt0) begin
      ram_wren  = m0_we;
    end
    if (rst) begin
      ram_addr  = '0;
      ram_wdata = '0;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = ram_q;
  assign m1_rdata  = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed tests with a scoreboard of expected grants and read data.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [11:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [11:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wren;
  logic [31:0] ram_q = '0;

  logic [31:0] mem [0:4095];

  int vectors = 0;
  int miscompares = 0;

  bit          exp_gnt[$];
  logic [31:0] exp_rd0[$];
  logic [31:0] exp_rd1[$];
  bit          mon_p;
  logic [31:0] mon_d;

  ram_arbiter #(.ADDR_W(12), .DATA_W(32), .LOCK_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM model, one-cycle read latency
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every grant and every rvalid must match the head of its queue
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_gnt || m1_gnt) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", {m0_gnt, m1_gnt}, 2'b00);
        else begin
          mon_p = exp_gnt.pop_front();
          chk("gnt_port", {m0_gnt, m1_gnt}, mon_p ? 2'b01 : 2'b10);
        end
      end
      if (m0_rvalid) begin
        if (exp_rd0.size() == 0) chk("m0_rvalid_unexpected", m0_rvalid, 0);
        else begin
          mon_d = exp_rd0.pop_front();
          chk("m0_rdata", m0_rdata, mon_d);
        end
      end
      if (m1_rvalid) begin
        if (exp_rd1.size() == 0) chk("m1_rvalid_unexpected", m1_rvalid, 0);
        else begin
          mon_d = exp_rd1.pop_front();
          chk("m1_rdata", m1_rdata, mon_d);
        end
      end
    end
  end

  // Issue one transfer on port p, hold until granted, then drop req
  task automatic op(input int p, input logic we, input logic [11:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    if (p == 0) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? m0_gnt : m1_gnt;
      @(posedge clk);
      #1;
    end
    if (!got) chk((p == 0) ? "m0_gnt_timeout" : "m1_gnt_timeout", 64'(got), 1);
    if (p == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
  endtask

  task automatic drained(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_gnt_left"}, 64'(exp_gnt.size()), 0);
    chk({tag, "_rd0_left"}, 64'(exp_rd0.size()), 0);
    chk({tag, "_rd1_left"}, 64'(exp_rd1.size()), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    m0_addr = 12'h0AB; m0_wdata = 32'h1111_1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_ram_wren", ram_wren, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m0_addr = '0; m0_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC000_0000 + 32'(i);
    mem[5] = 32'hDEAD_BEEF;

    // Test 1: single core read after reset
    do_reset();
    exp_gnt.push_back(1'b0);
    exp_rd0.push_back(32'hDEAD_BEEF);
    op(0, 1'b0, 12'h005, 32'h0);
    @(negedge clk);
    chk("t1_m1_rvalid", m1_rvalid, 0);
    drained("t1");

    // Test 2: both ports contend continuously, no lock -> strict alternation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_gnt.push_back(1'b0);
      exp_gnt.push_back(1'b1);
    end
    exp_rd0.push_back(32'hC000_0010); exp_rd0.push_back(32'hC000_0011); exp_rd0.push_back(32'hC000_0012);
    exp_rd1.push_back(32'hC000_0020); exp_rd1.push_back(32'hC000_0021); exp_rd1.push_back(32'hC000_0022);
    fork
      begin for (int i = 0; i < 3; i++) op(0, 1'b0, 12'(12'h010 + i), 32'h0); end
      begin for (int i = 0; i < 3; i++) op(1, 1'b0, 12'(12'h020 + i), 32'h0); end
    join
    drained("t2");

    // Test 3: locked burst of 40 writes against continuous core reads
    do_reset();
    m1_lock = 1'b1;
    for (int i = 0; i < 16; i++) exp_gnt.push_back(1'b1);
    exp_gnt.push_back(1'b0);
    for (int i = 0; i < 16; i++) exp_gnt.push_back(1'b1);
    exp_gnt.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_gnt.push_back(1'b1);
    exp_gnt.push_back(1'b0);
    exp_gnt.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_rd0.push_back(32'hC000_0200 + 32'(i));
    fork
      begin for (int i = 0; i < 40; i++) op(1, 1'b1, 12'(12'h300 + i), 32'h5000_0000 + 32'(i)); end
      begin for (int i = 0; i < 4; i++) op(0, 1'b0, 12'(12'h200 + i), 32'h0); end
    join
    m1_lock = 1'b0;
    drained("t3");
    for (int i = 0; i < 40; i++) chk("t3_mem", mem[12'(12'h300 + i)], 32'h5000_0000 + 32'(i));

    // Test 4: port-1 write then immediate port-0 read of the same word
    do_reset();
    exp_gnt.push_back(1'b1);
    exp_gnt.push_back(1'b0);
    exp_rd0.push_back(32'h0A5A_5A5A);
    op(1, 1'b1, 12'h100, 32'h0A5A_5A5A);
    op(0, 1'b0, 12'h100, 32'h0);
    drained("t4");

    // Test 5: reset lands between a granted read and its data cycle
    do_reset();
    exp_gnt.push_back(1'b0);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 12'h006;
    @(negedge clk);
    #2;
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'h0FF; m1_wdata = 32'h0000_1234;
    #1;
    chk("t5_wren_in_rst", ram_wren, 0);
    chk("t5_m1_gnt_in_rst", m1_gnt, 0);
    @(posedge clk);
    #1;
    chk("t5_m0_rvalid", m0_rvalid, 0);
    chk("t5_wren_in_rst2", ram_wren, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m1_req = 1'b0;
    exp_gnt.push_back(1'b0);
    exp_gnt.push_back(1'b1);
    exp_rd0.push_back(32'hC000_0007);
    fork
      op(0, 1'b0, 12'h007, 32'h0);
      op(1, 1'b1, 12'h0FF, 32'h0000_1234);
    join
    drained("t5");
    chk("t5_mem", mem[12'h0FF], 32'h0000_1234);

    // Test 6: core request withdrawn while port 1 holds the lock
    do_reset();
    m1_lock = 1'b1;
    for (int i = 0; i < 3; i++) exp_gnt.push_back(1'b1);
    fork
      begin for (int i = 0; i < 3; i++) op(1, 1'b1, 12'(12'h3E0 + i), 32'h6000_0000 + 32'(i)); end
      begin
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h3F0; m0_wdata = 32'h0000_0BAD;
        @(posedge clk);
        #1;
        m0_req = 1'b0;
      end
    join
    m1_lock = 1'b0;
    drained("t6");
    chk("t6_mem_untouched", mem[12'h3F0], 32'hC000_03F0);
    for (int i = 0; i < 3; i++) chk("t6_mem", mem[12'(12'h3E0 + i)], 32'h6000_0000 + 32'(i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
